normalize: RTL and testbench

NORMALIZE -- requirements
Module: normalize

---
 rtl/normalize.sv | 141 ++++++++++++++
 tb/tb_normalize.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/normalize.sv
// -----------------------------------------------------------------------------
// normalize
//   Iterative normalizer: finds how many single-bit shifts bring an 8-bit
//   operand into normal form, one shift per clock, and reports the shifted
//   value together with the shift count.
//
//   Modes (latched at the start request):
//     00 unsigned  : shift left until the MSB is set
//     01 signed    : shift left until bit 7 differs from bit 6
//     10 trailing  : shift right until the LSB is set
//     11 pass      : no shifting, result equals the operand
//   Every mode also stops on an all-zero operand or after 7 shifts.
//
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  request, honoured only while idle
//   mode      in   2  operation select, captured with start
//   in        in   8  operand, captured with start
//   out       out  8  registered normalized result
//   shiftVal  out  3  registered number of shifts applied
//   zero      out  1  registered, captured operand was 0x00
//   busy      out  1  high while shifting
//   done      out  1  one-cycle completion pulse
// -----------------------------------------------------------------------------
module normalize (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic [2:0] shiftVal,
  output logic       zero,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_work;
  logic [2:0] r_count;
  logic [1:0] r_mode;
  logic [7:0] r_out;
  logic [2:0] r_shift;
  logic       r_zero;

  logic       w_term;
  logic       w_mode_term;
  logic [7:0] w_work_shifted;

  // Per-mode stop condition; zero operand and the 7-shift ceiling apply to
  // all modes so the count can never wrap.
  always_comb begin
    w_mode_term = 1'b1;
    case (r_mode)
      2'b00:   w_mode_term = r_work[7];
      2'b01:   w_mode_term = r_work[7] ^ r_work[6];
      2'b10:   w_mode_term = r_work[0];
      default: w_mode_term = 1'b1;
    endcase
    w_term = w_mode_term || (r_work == 8'h00) || (r_count == 3'd7);
  end

  assign w_work_shifted = (r_mode == 2'b10) ? {1'b0, r_work[7:1]}
                                            : {r_work[6:0], 1'b0};

  // Next-state and status decode.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_term) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: capture on the accepted start, shift while running, publish
  // the result only on the run-to-done edge so outputs hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= 8'h00;
      r_count <= 3'd0;
      r_mode  <= 2'b00;
      r_out   <= 8'h00;
      r_shift <= 3'd0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work  <= in;
            r_count <= 3'd0;
            r_mode  <= mode;
          end
        end
        S_RUN: begin
          if (w_term) begin
            r_out   <= r_work;
            r_shift <= r_count;
            r_zero  <= (r_work == 8'h00);
          end else begin
            r_work  <= w_work_shifted;
            r_count <= r_count + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out      = r_out;
  assign shiftVal = r_shift;
  assign zero     = r_zero;

endmodule

// File: tb/tb_normalize.sv
// -----------------------------------------------------------------------------
// tb_normalize
//   Self-checking bench for normalize: directed vector table, randomized
//   operations against an arithmetic reference, and an abort/restart sequence.
// -----------------------------------------------------------------------------
module tb_normalize;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] in;
  logic [7:0] out;
  logic [2:0] shiftVal;
  logic       zero;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;

  normalize dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .in       (in),
    .out      (out),
    .shiftVal (shiftVal),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference: shift count derived from bit positions of the operand.
  function automatic void ref_model(input logic [1:0] m, input logic [7:0] d,
                                    output logic [7:0] o, output int n);
    int k;
    n = 0;
    if (d != 8'h00 && m != 2'b11) begin
      case (m)
        2'b00: begin
          for (int p = 0; p < 8; p++) if (d[p]) n = 7 - p;
        end
        2'b01: begin
          k = 1;
          while (k < 8 && d[7-k] == d[7]) k++;
          n = k - 1;
        end
        default: begin
          for (int p = 7; p >= 0; p--) if (d[p]) n = p;
        end
      endcase
    end
    if (n > 7) n = 7;
    if (m == 2'b10)      o = d >> n;
    else if (m == 2'b11) o = d;
    else                 o = d << n;
  endfunction

  // Runs one operation. lat is the edge index after which done was seen
  // (-1 if never), busy_cnt the number of cycles busy was high, hold_ok
  // whether outputs kept the prior result during the run, pulse_ok whether
  // done dropped again after a single cycle.
  task automatic run_op(input logic [1:0] m, input logic [7:0] d,
                        input bit noisy,
                        output logic [7:0] o, output logic [2:0] s,
                        output logic z, output int lat, output int busy_cnt,
                        output bit hold_ok, output bit pulse_ok);
    logic [11:0] prev;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    in    = d;
    prev  = {out, shiftVal, zero};
    @(negedge clk);
    start    = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    hold_ok  = 1'b1;
    pulse_ok = 1'b0;
    o = 8'h00; s = 3'd0; z = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      if ({out, shiftVal, zero} !== prev) hold_ok = 1'b0;
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom);
        in    = 8'($urandom);
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      o = out; s = shiftVal; z = zero;
      start = 1'b0;
      @(negedge clk);
      pulse_ok = !done && !busy;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic [2:0] exp_sh;
    logic       exp_zero;
    int         exp_lat;
  } vec_t;

  vec_t vecs [9];

  logic [7:0] g_o, r_o;
  logic [2:0] g_s;
  logic       g_z;
  int         g_lat, g_busy, r_n, seen;
  bit         g_hold, g_pulse;
  logic [1:0] rm;
  logic [7:0] rd;

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{2'b00, 8'h10, 8'h80, 3'd3, 1'b0, 4};
    vecs[1] = '{2'b01, 8'hF3, 8'h98, 3'd3, 1'b0, 4};
    vecs[2] = '{2'b01, 8'hFF, 8'h80, 3'd7, 1'b0, 8};
    vecs[3] = '{2'b10, 8'h28, 8'h05, 3'd3, 1'b0, 4};
    vecs[4] = '{2'b10, 8'h00, 8'h00, 3'd0, 1'b1, 1};
    vecs[5] = '{2'b11, 8'h5A, 8'h5A, 3'd0, 1'b0, 1};
    vecs[6] = '{2'b00, 8'h01, 8'h80, 3'd7, 1'b0, 8};
    vecs[7] = '{2'b10, 8'h80, 8'h01, 3'd7, 1'b0, 8};
    vecs[8] = '{2'b01, 8'h00, 8'h00, 3'd0, 1'b1, 1};

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    in    = 8'h00;
    #1;
    check("reset_out",   int'(out),      0);
    check("reset_shift", int'(shiftVal), 0);
    check("reset_zero",  int'(zero),     0);
    check("reset_busy",  int'(busy),     0);
    check("reset_done",  int'(done),     0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].mode, vecs[i].din, 1'b0, g_o, g_s, g_z, g_lat, g_busy,
             g_hold, g_pulse);
      $display("vec %0d mode=%0d in=0x%02h -> out=0x%02h sh=%0d z=%0d lat=%0d",
               i, vecs[i].mode, vecs[i].din, g_o, g_s, g_z, g_lat);
      check("vec_out",   int'(g_o), int'(vecs[i].exp_out));
      check("vec_shift", int'(g_s), int'(vecs[i].exp_sh));
      check("vec_zero",  int'(g_z), int'(vecs[i].exp_zero));
      check("vec_lat",   g_lat,     vecs[i].exp_lat);
      check("vec_busy",  g_busy,    vecs[i].exp_lat);
      check("vec_hold",  int'(g_hold),  1);
      check("vec_pulse", int'(g_pulse), 1);
    end

    // Randomized operations with noisy inputs during the run.
    for (int i = 0; i < 150; i++) begin
      rm = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       rd = 8'h00;
        1:       rd = 8'hFF;
        2:       rd = 8'h01 << $urandom_range(0, 7);
        default: rd = 8'($urandom);
      endcase
      ref_model(rm, rd, r_o, r_n);
      run_op(rm, rd, 1'b1, g_o, g_s, g_z, g_lat, g_busy, g_hold, g_pulse);
      $display("rnd %0d mode=%0d in=0x%02h -> out=0x%02h sh=%0d z=%0d lat=%0d",
               i, rm, rd, g_o, g_s, g_z, g_lat);
      check("rnd_out",   int'(g_o), int'(r_o));
      check("rnd_shift", int'(g_s), r_n);
      check("rnd_zero",  int'(g_z), int'(rd == 8'h00));
      check("rnd_lat",   g_lat,     r_n + 1);
      check("rnd_hold",  int'(g_hold),  1);
      check("rnd_pulse", int'(g_pulse), 1);
    end

    // Abort: start 0x01/mode 00, re-request at edge 3, reset before edge 4.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; in = 8'h01;
    @(negedge clk);                      // after edge 0
    start = 1'b0;
    @(negedge clk);                      // after edge 1
    @(negedge clk);                      // after edge 2
    start = 1'b1;
    @(negedge clk);                      // after edge 3
    start = 1'b0;
    check("abort_busy_run", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    $display("abort: busy=%0d done=%0d out=0x%02h sh=%0d", busy, done, out, shiftVal);
    check("abort_busy",  int'(busy),     0);
    check("abort_done",  int'(done),     0);
    check("abort_out",   int'(out),      0);
    check("abort_shift", int'(shiftVal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 0);

    run_op(2'b00, 8'h40, 1'b0, g_o, g_s, g_z, g_lat, g_busy, g_hold, g_pulse);
    $display("restart mode=0 in=0x40 -> out=0x%02h sh=%0d lat=%0d", g_o, g_s, g_lat);
    check("restart_out",   int'(g_o), 8'h80);
    check("restart_shift", int'(g_s), 1);
    check("restart_lat",   g_lat,     2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
